// File: rtl/aes_pkg.sv
// AES GF(2^8) helpers shared by the MixColumns datapath.
// Constant multipliers are composed from xtime only, so they map to XOR trees.
package aes_pkg;

  localparam logic [7:0] AES_POLY_RED = 8'h1B;

  typedef logic [7:0]        byte_t;
  typedef logic [3:0][7:0]   column_t;
  typedef logic [127:0]      state_t;

  function automatic byte_t xtime(input byte_t a);
    xtime = {a[6:0], 1'b0} ^ (a[7] ? AES_POLY_RED : 8'h00);
  endfunction

  function automatic byte_t gmul2(input byte_t a);
    gmul2 = xtime(a);
  endfunction

  function automatic byte_t gmul3(input byte_t a);
    gmul3 = xtime(a) ^ a;
  endfunction

  function automatic byte_t gmul9(input byte_t a);
    gmul9 = xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic byte_t gmulB(input byte_t a);
    byte_t x2;
    x2    = xtime(a);
    gmulB = xtime(xtime(x2)) ^ x2 ^ a;
  endfunction

  function automatic byte_t gmulD(input byte_t a);
    byte_t x4;
    x4    = xtime(xtime(a));
    gmulD = xtime(x4) ^ x4 ^ a;
  endfunction

  function automatic byte_t gmulE(input byte_t a);
    byte_t x2, x4;
    x2    = xtime(a);
    x4    = xtime(x2);
    gmulE = xtime(x4) ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/mix_single_column.sv
// One AES column through MixColumns (encrypt_i=1) or InvMixColumns (encrypt_i=0).
// Row 0 is the most significant byte of the 32-bit column.
module mix_single_column
  import aes_pkg::*;
(
  input  logic    encrypt_i,
  input  column_t col_i,
  output column_t col_o
);

  byte_t a0, a1, a2, a3;
  byte_t b0, b1, b2, b3;

  assign a0 = col_i[3];
  assign a1 = col_i[2];
  assign a2 = col_i[1];
  assign a3 = col_i[0];

  always_comb begin
    if (encrypt_i) begin
      b0 = gmul2(a0) ^ gmul3(a1) ^ a2        ^ a3;
      b1 = a0        ^ gmul2(a1) ^ gmul3(a2) ^ a3;
      b2 = a0        ^ a1        ^ gmul2(a2) ^ gmul3(a3);
      b3 = gmul3(a0) ^ a1        ^ a2        ^ gmul2(a3);
    end else begin
      b0 = gmulE(a0) ^ gmulB(a1) ^ gmulD(a2) ^ gmul9(a3);
      b1 = gmul9(a0) ^ gmulE(a1) ^ gmulB(a2) ^ gmulD(a3);
      b2 = gmulD(a0) ^ gmul9(a1) ^ gmulE(a2) ^ gmulB(a3);
      b3 = gmulB(a0) ^ gmulD(a1) ^ gmul9(a2) ^ gmulE(a3);
    end
  end

  assign col_o = {b0, b1, b2, b3};

endmodule

// File: rtl/mix_column.sv
// AES (Inv)MixColumns over a 128-bit state, one registered stage with valid.
// Define MIXCOL_COMB_OUT_EN for a purely combinational, zero-latency variant.
module mix_column
  import aes_pkg::*;
(
  input  logic         clock,
  input  logic         n_rst,
  input  logic         in_valid,
  input  logic         encrypt,
  input  logic [127:0] state_in,
  output logic [127:0] state_out,
  output logic         out_valid
);

  localparam int NUM_COLS = 4;

  state_t mix;

  // Column c occupies bits [127-32c -: 32]; columns never interact.
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    mix_single_column u_col (
      .encrypt_i (encrypt),
      .col_i     (state_in[127-32*c -: 32]),
      .col_o     (mix[127-32*c -: 32])
    );
  end

`ifdef MIXCOL_COMB_OUT_EN
  logic unused_clk_rst;
  assign unused_clk_rst = clock ^ n_rst;
  assign state_out      = mix;
  assign out_valid      = in_valid;
`else
  state_t state_q, state_d;
  logic   out_valid_q, out_valid_d;

  always_comb begin
    state_d     = state_q;
    out_valid_d = in_valid;
    if (in_valid) state_d = mix;
  end

  always_ff @(posedge clock) begin
    if (!n_rst) begin
      state_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign state_out = state_q;
  assign out_valid = out_valid_q;
`endif

endmodule

// File: tb/tb_mix_column.sv
// Self-checking bench for mix_column: directed vectors plus random traffic
// compared against a matrix-based GF(2^8) reference model.
module tb_mix_column;

  logic         clock = 1'b0;
  logic         n_rst;
  logic         in_valid;
  logic         encrypt;
  logic [127:0] state_in;
  logic [127:0] state_out;
  logic         out_valid;

  int total = 0;
  int bad   = 0;

  mix_column dut (
    .clock     (clock),
    .n_rst     (n_rst),
    .in_valid  (in_valid),
    .encrypt   (encrypt),
    .state_in  (state_in),
    .state_out (state_out),
    .out_valid (out_valid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Shift-and-add multiply in GF(2^8) mod 0x11B.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
    end
    return p;
  endfunction

  // Circulant matrix product: b_r = sum_j m[(j-r) mod 4] * a_j.
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic enc);
    logic [7:0] m [4];
    logic [7:0] a [4];
    logic [7:0] acc;
    logic [127:0] o;
    if (enc) begin m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01; end
    else     begin m[0] = 8'h0E; m[1] = 8'h0B; m[2] = 8'h0D; m[3] = 8'h09; end
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gm(a[j], m[(j - r + 4) % 4]);
        o[127-8*(4*c+r) -: 8] = acc;
      end
    end
    return o;
  endfunction

  // Drive one valid transfer and check it one edge later.
  task automatic xfer(input string tag, input logic enc, input logic [127:0] din,
                      input logic [127:0] exp);
    in_valid = 1'b1;
    encrypt  = enc;
    state_in = din;
    @(posedge clock); #1;
    chk({tag, "_vld"}, {127'd0, out_valid}, 128'd1);
    chk(tag, state_out, exp);
  endtask

  localparam logic [127:0] V_IN  = 128'h10012002300340045005600670078008;
  localparam logic [127:0] V_FWD = 128'h0170571521f2bf1bc9fc9f9961ed7407;
  localparam logic [127:0] V_INV = 128'h42ff149a6f7bf1928a73dc1635682082;
  localparam logic [127:0] V_FIX = 128'h25252525252525252525252525252525;
  localparam logic [127:0] V_STD = 128'hdb135345f20a225c01010101c6c6c6c6;
  localparam logic [127:0] V_STO = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;

  logic [127:0] held, d, e;
  logic         ev, exp_v;

  initial begin
    n_rst    = 1'b0;
    in_valid = 1'b0;
    encrypt  = 1'b1;
    state_in = '0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("rst_state", state_out, '0);
    chk("rst_vld", {127'd0, out_valid}, 128'd0);
    n_rst = 1'b1;

    xfer("fwd_vec", 1'b1, V_IN, V_FWD);
    chk("fwd_model", V_FWD, ref_mix(V_IN, 1'b1));
    xfer("inv_vec", 1'b0, V_IN, V_INV);
    xfer("roundtrip", 1'b0, V_FWD, V_IN);
    xfer("fix_enc", 1'b1, V_FIX, V_FIX);
    xfer("fix_dec", 1'b0, V_FIX, V_FIX);
    xfer("zero_enc", 1'b1, '0, '0);
    xfer("zero_dec", 1'b0, '0, '0);
    xfer("fips_enc", 1'b1, V_STD, V_STO);
    xfer("fips_dec", 1'b0, V_STO, V_STD);

    // Back-to-back alternating modes, in_valid held high.
    for (int i = 0; i < 8; i++) begin
      d  = {$urandom, $urandom, $urandom, $urandom};
      ev = i[0];
      xfer($sformatf("b2b%0d", i), ev, d, ref_mix(d, ev));
    end
    held = state_out;

    in_valid = 1'b0;
    state_in = ~held;
    @(posedge clock); #1;
    chk("drop_vld", {127'd0, out_valid}, 128'd0);
    chk("drop_hold", state_out, held);

    // Reset wins over a simultaneous valid input.
    n_rst    = 1'b0;
    in_valid = 1'b1;
    encrypt  = 1'b1;
    state_in = V_IN;
    @(posedge clock); #1;
    chk("rst_ovr_state", state_out, '0);
    chk("rst_ovr_vld", {127'd0, out_valid}, 128'd0);
    n_rst = 1'b1;
    xfer("post_rst", 1'b1, V_IN, V_FWD);

    // Random traffic with gaps.
    exp_v = 1'b1;
    e     = V_FWD;
    for (int i = 0; i < 300; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      encrypt  = $urandom_range(0, 1);
      state_in = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 9) == 0) state_in = '0;
      if (in_valid) e = ref_mix(state_in, encrypt);
      exp_v = in_valid;
      if (in_valid && $urandom_range(0, 1) == 1) begin
        d = ref_mix(state_in, encrypt);
        chk("rnd_inv_model", ref_mix(d, ~encrypt), state_in);
      end
      @(posedge clock); #1;
      chk("rnd_vld", {127'd0, out_valid}, {127'd0, exp_v});
      chk("rnd_data", state_out, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mix_column.md
Name: mix_column

Overview:
- AES MixColumns (encrypt) / InvMixColumns (decrypt) diffusion stage over a 128-bit state.
- Used in the round datapath between ShiftRows and AddRoundKey.
- Mode is selected per transfer by the encrypt input.
- Single-cycle registered stage with a simple valid pipeline.

Parameters:
- None. Width is fixed at 128-bit state, 4 columns of 4 bytes.

Ports:
- clock      input   1    rising-edge clock
- n_rst      input   1    synchronous active-low reset
- in_valid   input   1    state_in/encrypt valid this cycle
- encrypt    input   1    1 = MixColumns, 0 = InvMixColumns
- state_in   input   128  input state
- state_out  output  128  transformed state, registered
- out_valid  output  1    state_out holds a new result

Behaviour:
- Clock and reset: one clock (clock); reset n_rst is synchronous, active-low.
- Byte mapping:
  - Byte k = state_in[127-8k -: 8], k = 0..15. Byte 0 is the MSB byte.
  - Column c = bytes 4c..4c+3. Row r = byte 4c+r.
  - Output uses the same mapping.
- Arithmetic: GF(2^8), reduction polynomial x^8+x^4+x^3+x+1 (0x11B).
  - xtime(a) = (a<<1) ^ (a[7] ? 0x1B : 0x00).
  - Addition is XOR.
- Encrypt, per column (a0..a3):
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
- Decrypt, per column:
  - b0 = Ea0^Ba1^Da2^9a3
  - b1 = 9a0^Ea1^Ba2^Da3
  - b2 = Da0^9a1^Ea2^Ba3
  - b3 = Ba0^Da1^9a2^Ea3
- Constant multipliers are built from xtime chains only; no general multiplier and no lookup ROM.
- Latency and handshake:
  - Latency is 1 cycle. On a rising edge with n_rst=1 and in_valid=1: state_out <= f(state_in, encrypt) and out_valid <= 1.
  - When in_valid=0: out_valid <= 0 and state_out holds its last value.
  - No backpressure. A new transfer is accepted every cycle.
  - encrypt is sampled together with state_in and may change every cycle.
- Reset:
  - When n_rst=0 at a rising edge: state_out <= 0, out_valid <= 0.
  - Reset overrides a simultaneous in_valid.
  - A transfer in flight is discarded.
  - The first valid input after reset is released produces out_valid one cycle later.
- Invariants:
  - The four columns are transformed independently.
  - A state with all bytes equal is unchanged in both modes.
  - Inverse(Forward(x)) == x.
  - All-zero input gives all-zero output.

Optional Feature:
- Macro MIXCOL_COMB_OUT_EN.
- Defined: output registers are removed. state_out = f(state_in, encrypt) combinationally and out_valid = in_valid (0 latency). clock and n_rst remain as ports but are unused.
- Not defined: registered 1-cycle behaviour as above.

Decomposition:
- Package aes_pkg holds:
  - AES_POLY_RED = 8'h1B
  - typedefs byte_t (logic [7:0]), column_t (4 x byte_t), state_t (logic [127:0])
  - functions xtime, gmul2, gmul3, gmul9, gmulB, gmulD, gmulE
- Sub-module mix_single_column:
  - 32-bit column in/out plus an encrypt input, purely combinational.
  - Instantiated 4 times; the top adds only the registers and valid logic.

Test Plan:
- Forward: reset, then in_valid=1, encrypt=1, state_in=10012002300340045005600670078008 -> next cycle out_valid=1, state_out=0170571521f2bf1bc9fc9f9961ed7407.
- Inverse: encrypt=0, same input -> state_out=42ff149a6f7bf1928a73dc1635682082. Also encrypt=0 with input 0170571521f2bf1bc9fc9f9961ed7407 -> 10012002300340045005600670078008 (round trip).
- Fixed point: 25252525252525252525252525252525 in both modes -> identical output; all-zero input -> all-zero output.
- Standard vector (FIPS-197 column): column db135345 encrypt -> 8e4da1bc; 8e4da1bc decrypt -> db135345.
- Back-to-back: alternate encrypt=1/0 on consecutive cycles with in_valid held high -> each result appears exactly one cycle later with matching mode. Drop in_valid -> out_valid=0 and state_out held.
- Reset: assert n_rst=0 in the same cycle as a valid input -> state_out=0, out_valid=0 next cycle; first output after release has 1-cycle latency.
